// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the unified memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter serves the requesters and drives the memory.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              win_d_q, win_d_d;
    logic [3:0]        starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              grant_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_d_q     <= 1'b0;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_d_q     <= win_d_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d_d     = win_d_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_i     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.i_req) starve_d = '0;
                if (bus.i_req || bus.d_req) begin
                    // D wins contention unless I has already waited out STARVE_MAX grants.
                    grant_i   = bus.i_req && (!bus.d_req || starve_q == STARVE_LIM);
                    win_d_d   = !grant_i;
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
                    if (grant_i) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end else begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        if (bus.i_req && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (win_d_q) begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the unified memory port arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic busy;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem[logic [31:0]];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    int          wc       = 0;
    bit          hold     = 1'b0;
    bit          stray    = 1'b0;

    int          cyc, cyc2, cap_cyc, cap_cyc2, k;
    logic [31:0] cap_addr, cap_addr2, cap_wdata;
    logic        cap_we, cap_we2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output int n, output int c_cyc,
                            output logic [31:0] c_addr, output logic c_we);
        bus.i_addr = addr;
        bus.i_req  = 1'b1;
        n = 0; c_cyc = -1; c_addr = '0; c_we = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            n++;
            if (bus.mem_req && c_cyc < 0) begin
                c_cyc = n; c_addr = bus.mem_addr; c_we = bus.mem_we;
            end
            if (bus.i_ready) break;
        end
        if (!bus.i_ready) check("i_timeout", 0, 1);
        bus.i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int n, output logic c_we, output logic [31:0] c_addr,
                           output logic [31:0] c_wdata);
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        n = 0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            n++;
            if (bus.mem_req && n == 1) begin
                c_we = bus.mem_we; c_addr = bus.mem_addr; c_wdata = bus.mem_wdata;
            end
            if (bus.d_ready) break;
        end
        if (!bus.d_ready) check("d_timeout", 0, 1);
        bus.d_req = 1'b0;
    endtask

    // Memory model: acks after lat waiting cycles, stores update the array.
    always @(negedge clk) begin
        if (bus.mem_req && !hold) begin
            if (wc >= lat) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    mem[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_rdata = 32'h5A5A_5A5A;
                end else begin
                    bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
                end
                wc = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0;
                wc++;
            end
        end else begin
            bus.mem_ack   = stray;
            bus.mem_rdata = 32'hBAD0_C0DE;
            wc = 0;
        end
    end

    // Scoreboard: every ready pulse consumes the next expected completion.
    always @(negedge clk) begin
        if (bus.i_ready || bus.d_ready) begin
            check("ready_excl", bus.i_ready & bus.d_ready, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_who", bus.d_ready, mon_e.is_d);
                check("rdata", bus.d_ready ? bus.d_rdata : bus.i_rdata, mon_e.rdata);
                if (bus.i_ready) check("starve_clr", dut.starve_q, 0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        mem[32'h10] = 32'h0000_0013;
        mem[32'h20] = 32'h0000_0093;

        repeat (2) @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_i_ready", bus.i_ready, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, zero latency
        lat = 0;
        push_exp(1'b0, 32'h0000_0013);
        do_fetch(32'h10, cyc, cap_cyc, cap_addr, cap_we);
        check("f_memreq_cycle", cap_cyc, 1);
        check("f_mem_addr", cap_addr, 32'h10);
        check("f_mem_we", cap_we, 0);
        check("f_ready_cycle", cyc, 2);
        check("f_i_rdata", bus.i_rdata, 32'h0000_0013);
        check("f_busy_resp", busy, 1);
        @(negedge clk);
        check("f_busy_idle", busy, 0);

        // Store then load, latency 2
        lat = 2;
        push_exp(1'b1, 32'h0);
        do_data(1'b1, 32'h40, 32'hDEAD_BEEF, cyc, cap_we, cap_addr, cap_wdata);
        check("st_mem_we", cap_we, 1);
        check("st_mem_addr", cap_addr, 32'h40);
        check("st_mem_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("st_ready_cycle", cyc, 4);
        check("st_d_rdata_kept", bus.d_rdata, 32'h0);
        @(negedge clk);
        push_exp(1'b1, 32'hDEAD_BEEF);
        do_data(1'b0, 32'h40, 32'h0, cyc, cap_we, cap_addr, cap_wdata);
        check("ld_mem_we", cap_we, 0);
        check("ld_ready_cycle", cyc, 4);
        check("ld_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Simultaneous requests: D first, I after exactly one transaction
        lat = 0;
        push_exp(1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 32'h0000_0013);
        fork
            do_data(1'b0, 32'h40, 32'h0, cyc, cap_we, cap_addr, cap_wdata);
            do_fetch(32'h10, cyc2, cap_cyc2, cap_addr2, cap_we2);
        join
        check("sim_d_cycles", cyc, 2);
        check("sim_i_cycles", cyc2, 5);
        @(negedge clk);

        // Starvation: both held, expect D,D,D,D,I,D,D,D,D,I
        lat = 1;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) push_exp(1'b1, 32'hDEAD_BEEF);
            push_exp(1'b0, 32'h0000_0093);
        end
        bus.i_addr = 32'h20; bus.d_addr = 32'h40; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        k = 0;
        for (int c = 0; c < 400 && k < 10; c++) begin
            @(negedge clk);
            if (bus.i_ready || bus.d_ready) k++;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("starve_completions", k, 10);
        @(negedge clk);

        // Stray ack while idle
        stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray_mem_req", bus.mem_req, 0);
            check("stray_busy", busy, 0);
            check("stray_ready", bus.i_ready | bus.d_ready, 0);
        end
        stray = 1'b0;
        @(negedge clk);

        // Reset while the memory withholds its ack
        lat = 0;
        hold = 1'b1;
        bus.i_addr = 32'h10; bus.i_req = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_mem_req", bus.mem_req, 1);
        check("hold_busy", busy, 1);
        reset = 1'b1; bus.i_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rstb_mem_req", bus.mem_req, 0);
        check("rstb_busy", busy, 0);
        check("rstb_ready", bus.i_ready | bus.d_ready, 0);
        check("rstb_starve", dut.starve_q, 0);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(1'b0, 32'h0000_0013);
        do_fetch(32'h10, cyc, cap_cyc, cap_addr, cap_we);
        check("rstb_fetch_cycles", cyc, 2);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
